// File: rtl/pc_sequencer_ras_pkg.sv
// Shared constants for the next-PC sequencer and its return-address stack.
// Holds no logic, so it adds no latency.
// Holds no flow control, so it has no backpressure behaviour.
package pc_sequencer_ras_pkg;

    // Default reset vector: the start of the MIPS user text segment
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // Source selection for the next fetch address
    typedef enum logic [1:0] {
        NEXT_PC_SEQ = 2'd0,
        NEXT_PC_BR  = 2'd1,
        NEXT_PC_J   = 2'd2,
        NEXT_PC_JR  = 2'd3
    } next_pc_sel_e;

    // Pointer width for a circular stack of the given depth (at least one bit)
    function automatic int ras_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pc_sequencer_ras_ras_stack.sv
// Circular return-address stack; when full, a push overwrites the oldest entry.
// Latency: top and count reflect a push or pop on the cycle after the clock edge.
// No backpressure: a pop while empty is ignored, and a push while full sets sticky overflow.
module ras_stack
    import pc_sequencer_ras_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = ras_ptr_w(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;   // next slot to write; the newest entry sits just below it
    logic [PTR_W-1:0] top_idx;
    logic             full;
    logic             do_pop;

    assign top_idx = wr_ptr - PTR_W'(1);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign top     = empty ? '0 : mem[top_idx];

    // Pointer, count, storage and sticky overflow update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (push && do_pop) begin
            // A simultaneous push and pop replaces the current top entry
            mem[top_idx] <= push_data;
        end else if (push) begin
            // When full, wr_ptr already points at the oldest entry, so that entry is overwritten
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (do_pop) begin
            wr_ptr <= top_idx;
            count  <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer_ras.sv
// Next-PC generator: sequential, BEQ/BNE, J/JAL, JR, and a return-address stack that checks JR $ra predictions.
// Latency: pc updates one cycle after the control inputs; pc, pc_plus4 and ras_top are combinational from registers.
// Backpressure: stall holds pc, the RAS and overflow for the cycle and suppresses the mispredict pulse.
module pc_sequencer_ras
    import pc_sequencer_ras_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          RAS_DEPTH = 4,
    localparam int         CNT_W     = $clog2(RAS_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              beq,
    input  logic              bne,
    input  logic              zero,
    input  logic              jump,
    input  logic              link,
    input  logic              jr,
    input  logic              jr_is_ra,
    input  logic [15:0]       imm16,
    input  logic [25:0]       target26,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] ras_top,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_mispredict,
    output logic              ras_overflow
);

    localparam logic [ADDR_W-1:0] RESET_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

    next_pc_sel_e      sel;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] jr_target;
    logic              taken;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_empty;

    assign pc_plus4  = pc + ADDR_W'(4);
    assign taken     = (beq & zero) | (bne & ~zero);
    assign br_target = pc_plus4 + ADDR_W'({{14{imm16[15]}}, imm16, 2'b00});
    assign jr_target = {jr_addr[ADDR_W-1:2], 2'b00};

    // Narrow builds have no region bits above the 28-bit jump field
    if (ADDR_W > 28) begin : g_jump_region
        assign j_target = {pc_plus4[ADDR_W-1:28], target26, 2'b00};
    end else begin : g_jump_trunc
        assign j_target = ADDR_W'({target26, 2'b00});
    end

    // JR outranks jump, so a JAL that coincides with a JR never pushes
    assign ras_push = jump & link & ~jr & ~stall;
    assign ras_pop  = jr & jr_is_ra & ~stall;

    // Next-PC source priority: jr > jump > taken branch > sequential
    always_comb begin
        sel = NEXT_PC_SEQ;
        if (jr) begin
            sel = NEXT_PC_JR;
        end else if (jump) begin
            sel = NEXT_PC_J;
        end else if (taken) begin
            sel = NEXT_PC_BR;
        end
    end

    // Next-PC mux
    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            NEXT_PC_BR: next_pc = br_target;
            NEXT_PC_J:  next_pc = j_target;
            NEXT_PC_JR: next_pc = jr_target;
            default:    next_pc = pc_plus4;
        endcase
    end

    // PC register; reset overrides stall
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_ALIGNED;
        end else if (!stall) begin
            pc <= next_pc;
        end
    end

    // One-cycle pulse when a JR $ra disagrees with the prediction or finds the stack empty
    always_ff @(posedge clk) begin
        if (reset) begin
            ras_mispredict <= 1'b0;
        end else begin
            ras_mispredict <= ras_pop & (ras_empty | (ras_top != jr_addr));
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .overflow  (ras_overflow)
    );

endmodule

// File: tb/tb_pc_sequencer_ras.sv
// Bench for pc_sequencer_ras: directed vector table, hand-written corner sequences, then randomized traffic against a queue model.
// Checks run one time unit after each rising edge.
// No flow control; the bench ends itself, with a watchdog as a backstop.
module tb_pc_sequencer_ras;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, reset16;
    logic        stall, beq, bne, zero, jump, link, jr, jr_is_ra;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] jr_addr;

    logic [31:0] pc, pc_plus4, ras_top;
    logic [2:0]  ras_count;
    logic        ras_mispredict, ras_overflow;

    logic [15:0] pc16, p4_16, top16;
    logic [2:0]  cnt16;
    logic        mp16, ov16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer_ras #(.ADDR_W(32), .RESET_PC(32'h0040_0000), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .beq(beq), .bne(bne), .zero(zero),
        .jump(jump), .link(link), .jr(jr), .jr_is_ra(jr_is_ra), .imm16(imm16),
        .target26(target26), .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4),
        .ras_top(ras_top), .ras_count(ras_count), .ras_mispredict(ras_mispredict),
        .ras_overflow(ras_overflow)
    );

    pc_sequencer_ras #(.ADDR_W(16), .RESET_PC(32'h0000_FFFF), .RAS_DEPTH(DEPTH)) dut16 (
        .clk(clk), .reset(reset16), .stall(stall), .beq(beq), .bne(bne), .zero(zero),
        .jump(jump), .link(link), .jr(jr), .jr_is_ra(jr_is_ra), .imm16(imm16),
        .target26(target26), .jr_addr(jr_addr[15:0]), .pc(pc16), .pc_plus4(p4_16),
        .ras_top(top16), .ras_count(cnt16), .ras_mispredict(mp16), .ras_overflow(ov16)
    );

    // Control byte layout: {stall, beq, bne, zero, jump, link, jr, jr_is_ra}
    localparam logic [7:0] C_SEQ  = 8'b0000_0000;
    localparam logic [7:0] C_STL  = 8'b1000_0000;
    localparam logic [7:0] C_BEQ  = 8'b0100_0000;
    localparam logic [7:0] C_BNE  = 8'b0010_0000;
    localparam logic [7:0] C_Z    = 8'b0001_0000;
    localparam logic [7:0] C_JAL  = 8'b0000_1100;
    localparam logic [7:0] C_LINK = 8'b0000_0100;
    localparam logic [7:0] C_JRX  = 8'b0000_0010;
    localparam logic [7:0] C_JRRA = 8'b0000_0011;

    typedef struct {
        logic [7:0]  ctl;
        logic [15:0] imm;
        logic [25:0] t26;
        logic [31:0] jra;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
        logic [31:0] e_top;
        logic        e_mp;
        logic        e_ov;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_mp, m_ov;

    function automatic vec_t mk(input logic [7:0] c, input logic [15:0] i, input logic [25:0] t,
                                input logic [31:0] a, input logic [31:0] p, input int n,
                                input logic [31:0] tp, input logic mp, input logic ov);
        vec_t v;
        v.ctl = c; v.imm = i; v.t26 = t; v.jra = a;
        v.e_pc = p; v.e_cnt = n; v.e_top = tp; v.e_mp = mp; v.e_ov = ov;
        return v;
    endfunction

    task automatic drive(input logic [7:0] c, input logic [15:0] i, input logic [25:0] t, input logic [31:0] a);
        {stall, beq, bne, zero, jump, link, jr, jr_is_ra} = c;
        imm16 = i; target26 = t; jr_addr = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model of one clock edge, derived from the stated rules using a queue for the stack
    task automatic model_step();
        logic [31:0] p4, npc;
        logic        pop, push, taken;
        int          off;
        if (stall) begin
            m_mp = 1'b0;
            return;
        end
        p4    = m_pc + 32'd4;
        taken = (beq && zero) || (bne && !zero);
        off   = $signed(imm16);
        if (jr)         npc = jr_addr & ~32'd3;
        else if (jump)  npc = (p4 & 32'hF000_0000) | ({6'd0, target26} << 2);
        else if (taken) npc = p4 + 32'(off * 4);
        else            npc = p4;
        pop  = jr && jr_is_ra;
        push = jump && link && !jr;
        m_mp = pop && (m_ras.size() == 0 || m_ras[$] != jr_addr);
        if (pop && m_ras.size() > 0) void'(m_ras.pop_back());
        if (push) begin
            m_ras.push_back(p4);
            if (m_ras.size() > DEPTH) begin
                void'(m_ras.pop_front());
                m_ov = 1'b1;
            end
        end
        m_pc = npc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; reset16 = 1'b1;
        drive(C_SEQ, 16'h0, 26'h0, 32'h0);
        step(); step();
        check("reset pc",    pc, 32'h0040_0000);
        check("reset count", 32'(ras_count), 32'd0);
        check("reset top",   ras_top, 32'd0);
        check("reset mp",    32'(ras_mispredict), 32'd0);
        check("reset ov",    32'(ras_overflow), 32'd0);
        reset = 1'b0;

        // Directed vectors: expected values are the state after the edge
        tbl.push_back(mk(C_SEQ, 0, 0, 0, 32'h0040_0004, 0, 0, 0, 0));
        tbl.push_back(mk(C_SEQ, 0, 0, 0, 32'h0040_0008, 0, 0, 0, 0));
        tbl.push_back(mk(C_SEQ, 0, 0, 0, 32'h0040_000C, 0, 0, 0, 0));
        tbl.push_back(mk(C_SEQ, 0, 0, 0, 32'h0040_0010, 0, 0, 0, 0));
        tbl.push_back(mk(C_BEQ | C_Z, 16'hFFFC, 0, 0, 32'h0040_0004, 0, 0, 0, 0));
        tbl.push_back(mk(C_SEQ, 0, 0, 0, 32'h0040_0008, 0, 0, 0, 0));
        tbl.push_back(mk(C_SEQ, 0, 0, 0, 32'h0040_000C, 0, 0, 0, 0));
        tbl.push_back(mk(C_SEQ, 0, 0, 0, 32'h0040_0010, 0, 0, 0, 0));
        tbl.push_back(mk(C_BEQ, 16'hFFFC, 0, 0, 32'h0040_0014, 0, 0, 0, 0));
        tbl.push_back(mk(C_BNE, 16'h0003, 0, 0, 32'h0040_0024, 0, 0, 0, 0));
        tbl.push_back(mk(C_JRX, 0, 0, 32'h0040_0003, 32'h0040_0000, 0, 0, 0, 0));
        tbl.push_back(mk(C_JAL, 0, 26'h0100040, 0, 32'h0040_0100, 1, 32'h0040_0004, 0, 0));
        tbl.push_back(mk(C_JRRA, 0, 0, 32'h0040_0004, 32'h0040_0004, 0, 0, 0, 0));
        tbl.push_back(mk(C_JAL, 0, 26'h0100040, 0, 32'h0040_0100, 1, 32'h0040_0008, 0, 0));
        tbl.push_back(mk(C_JAL, 0, 26'h0100080, 0, 32'h0040_0200, 2, 32'h0040_0104, 0, 0));
        tbl.push_back(mk(C_JAL, 0, 26'h01000C0, 0, 32'h0040_0300, 3, 32'h0040_0204, 0, 0));
        tbl.push_back(mk(C_JAL, 0, 26'h0100100, 0, 32'h0040_0400, 4, 32'h0040_0304, 0, 0));
        tbl.push_back(mk(C_JAL, 0, 26'h0100140, 0, 32'h0040_0500, 4, 32'h0040_0404, 0, 1));
        tbl.push_back(mk(C_JRRA, 0, 0, 32'h0040_0404, 32'h0040_0404, 3, 32'h0040_0304, 0, 1));
        tbl.push_back(mk(C_JRRA, 0, 0, 32'h0040_0304, 32'h0040_0304, 2, 32'h0040_0204, 0, 1));
        tbl.push_back(mk(C_JRRA, 0, 0, 32'h0040_0204, 32'h0040_0204, 1, 32'h0040_0104, 0, 1));
        tbl.push_back(mk(C_JRRA, 0, 0, 32'h0040_0104, 32'h0040_0104, 0, 0, 0, 1));
        tbl.push_back(mk(C_JRRA, 0, 0, 32'h0040_0008, 32'h0040_0008, 0, 0, 1, 1));
        tbl.push_back(mk(C_SEQ, 0, 0, 0, 32'h0040_000C, 0, 0, 0, 1));
        tbl.push_back(mk(C_JAL, 0, 26'h0100040, 0, 32'h0040_0100, 1, 32'h0040_0010, 0, 1));
        tbl.push_back(mk(C_JAL | C_JRRA, 0, 26'h0100040, 32'h0040_0020, 32'h0040_0020, 0, 0, 1, 1));
        tbl.push_back(mk(C_STL | C_JAL, 0, 26'h0100080, 0, 32'h0040_0020, 0, 0, 0, 1));
        tbl.push_back(mk(C_STL | C_JAL, 0, 26'h0100080, 0, 32'h0040_0020, 0, 0, 0, 1));
        tbl.push_back(mk(C_STL | C_JAL, 0, 26'h0100080, 0, 32'h0040_0020, 0, 0, 0, 1));
        tbl.push_back(mk(C_JAL, 0, 26'h0100080, 0, 32'h0040_0200, 1, 32'h0040_0024, 0, 1));
        tbl.push_back(mk(C_LINK, 0, 0, 0, 32'h0040_0204, 1, 32'h0040_0024, 0, 1));
        tbl.push_back(mk(C_BEQ | C_BNE, 16'h0001, 0, 0, 32'h0040_020C, 1, 32'h0040_0024, 0, 1));
        tbl.push_back(mk(C_BEQ | C_BNE | C_Z, 16'h0001, 0, 0, 32'h0040_0214, 1, 32'h0040_0024, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].ctl, tbl[i].imm, tbl[i].t26, tbl[i].jra);
            step();
            check($sformatf("vec%0d pc", i),    pc, tbl[i].e_pc);
            check($sformatf("vec%0d pc4", i),   pc_plus4, tbl[i].e_pc + 32'd4);
            check($sformatf("vec%0d count", i), 32'(ras_count), tbl[i].e_cnt);
            check($sformatf("vec%0d top", i),   ras_top, tbl[i].e_top);
            check($sformatf("vec%0d mp", i),    32'(ras_mispredict), 32'(tbl[i].e_mp));
            check($sformatf("vec%0d ov", i),    32'(ras_overflow), 32'(tbl[i].e_ov));
        end

        // Reset while stalled with two live entries and overflow set
        drive(C_JAL, 0, 26'h0100040, 0);
        step();
        check("pre-reset count", 32'(ras_count), 32'd2);
        check("pre-reset top",   ras_top, 32'h0040_0218);
        reset = 1'b1;
        drive(C_STL | C_JAL, 0, 26'h0100080, 0);
        step();
        check("mid reset pc",    pc, 32'h0040_0000);
        check("mid reset count", 32'(ras_count), 32'd0);
        check("mid reset ov",    32'(ras_overflow), 32'd0);
        check("mid reset top",   ras_top, 32'd0);
        reset = 1'b0;

        // Randomized traffic against the model
        m_pc = 32'h0040_0000; m_ras.delete(); m_mp = 1'b0; m_ov = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [7:0] c;
            logic [31:0] a;
            case ($urandom_range(0, 7))
                0, 1, 2: c = {1'b0, 3'($urandom), 4'b0000};
                3:       c = C_JAL;
                4:       c = C_JRRA;
                5:       c = C_JRX;
                6:       c = 8'b0000_1000;
                default: c = 8'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) c[7] = 1'b1;
            else c[7] = 1'b0;
            if (m_ras.size() > 0 && $urandom_range(0, 2) != 0) a = m_ras[$];
            else a = $urandom;
            drive(c, 16'($urandom), 26'($urandom), a);
            model_step();
            step();
            check($sformatf("rnd%0d pc", n),    pc, m_pc);
            check($sformatf("rnd%0d count", n), 32'(ras_count), m_ras.size());
            check($sformatf("rnd%0d top", n),   ras_top, (m_ras.size() > 0) ? m_ras[$] : 32'd0);
            check($sformatf("rnd%0d mp", n),    32'(ras_mispredict), 32'(m_mp));
            check($sformatf("rnd%0d ov", n),    32'(ras_overflow), 32'(m_ov));
        end

        // 16-bit build: reset vector masking and sequential wrap past the top of the address space
        drive(C_SEQ, 0, 0, 0);
        reset16 = 1'b1;
        step();
        check("a16 reset pc",    32'(pc16), 32'h0000_FFFC);
        check("a16 reset count", 32'(cnt16), 32'd0);
        reset16 = 1'b0;
        step();
        check("a16 wrap pc", 32'(pc16), 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer_ras.md
Name: pc_sequencer_ras

Overview:
- Parametrised next-PC generator for the single-cycle MIPS machine.
- Replaces the fixed 30-bit PC register/adder/mux chain.
- Adds: configurable address width and reset vector, BEQ/BNE, J/JAL/JR, a fetch stall, and a circular return-address stack (RAS) with JR $ra prediction checking.
- Sits between the decoder (control inputs), the regfile/ALU (zero flag, rs data) and instruction memory (PC out).

Parameters:
- ADDR_W, 32, byte-address width; legal range 16..32; PC[1:0] is always 0.
- RESET_PC, 32'h0040_0000, byte address loaded on reset; bits [1:0] ignored.
- RAS_DEPTH, 4, RAS entries; power of two, 2..16.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC and RAS this cycle
- beq  in  1  current instruction is BEQ
- bne  in  1  current instruction is BNE
- zero  in  1  ALU zero flag
- jump  in  1  J or JAL
- link  in  1  JAL; valid only with jump
- jr  in  1  JR
- jr_is_ra  in  1  JR source register is $31
- imm16  in  16  branch offset in words
- target26  in  26  jump word-index field
- jr_addr  in  ADDR_W  rs register value
- pc  out  ADDR_W  current fetch address
- pc_plus4  out  ADDR_W  pc+4; this is the JAL link value
- ras_top  out  ADDR_W  predicted return address; 0 when empty
- ras_count  out  $clog2(RAS_DEPTH)+1  valid entries
- ras_mispredict  out  1  1-cycle pulse: a JR $ra popped a value different from jr_addr
- ras_overflow  out  1  sticky: a push happened while the RAS was full

Behaviour:
- Reset is synchronous. On a reset edge:
  - pc = RESET_PC with bits [1:0] forced to 00.
  - ras_count = 0, ras_mispredict = 0, ras_overflow = 0.
  - All RAS entries are cleared to 0.
  - Reset overrides every other input, including stall and any operation in progress.
- pc, pc_plus4 and ras_top are combinational from registers. All state changes on the rising clk edge.
- Next-PC priority: reset > stall > jr > jump > taken branch > sequential.
- Taken branch = (beq & zero) | (bne & ~zero).
- Address arithmetic:
  - Sequential: pc_plus4 = pc + 4, modulo 2^ADDR_W.
  - Branch target: pc_plus4 + (sext(imm16) << 2), modulo 2^ADDR_W. Wrap-around is silent.
  - Jump target: {pc_plus4[ADDR_W-1:28], target26, 2'b00} when ADDR_W > 28. Otherwise {target26, 2'b00} truncated to ADDR_W bits.
  - JR target: jr_addr with bits [1:0] forced to 00.
- Stall: pc, the RAS and ras_overflow all hold. ras_mispredict is 0 during a stalled cycle.
- RAS push (jump & link & ~stall):
  - pc_plus4 is written at the top pointer.
  - ras_count saturates at RAS_DEPTH.
  - When full, the write overwrites the oldest entry (circular) and sets ras_overflow.
- RAS pop (jr & jr_is_ra & ~stall):
  - ras_count decrements and ras_mispredict = (ras_top != jr_addr) on the next cycle.
  - When the RAS is empty there is no pop: ras_count stays 0 and ras_mispredict = 1.
  - The PC always follows jr_addr. The prediction is informational only.
- JR with jr_is_ra = 0: no RAS change, no mispredict.
- jump and jr asserted together: jr wins. No push, but the pop still happens.
- link without jump: ignored.
- beq and bne together: either taken condition redirects the PC.

Decomposition:
- Shared package constants: reset-vector default, NEXT_PC_SEQ/BR/J/JR select encodings, RAS pointer width function.
- One sub-module, ras_stack: circular buffer with push, pop, top, count and overflow. Parametrised by depth and width.
- The top level holds the PC register, the adders and the next-PC priority mux.

Test Plan:
- Reset, then 3 unstalled cycles -> pc = 0x00400000, 0x00400004, 0x00400008. ras_count = 0.
- At pc = 0x00400010: beq=1, zero=1, imm16=0xFFFC -> next pc = 0x00400004. Same with zero=0 -> 0x00400014. bne=1, zero=0, imm16=3 -> 0x00400020.
- At pc = 0x00400000: jump=1, link=1, target26=0x0100040 -> pc = 0x00400100, ras_top = 0x00400004, ras_count = 1. Then jr=1, jr_is_ra=1, jr_addr=0x00400004 -> pc = 0x00400004, ras_count = 0, no mispredict.
- 5 JALs with RAS_DEPTH=4 -> ras_count = 4 and ras_overflow = 1. 4 matching returns succeed. A 5th JR $ra -> ras_mispredict pulse, ras_count stays 0.
- stall=1 held for 3 cycles during a JAL -> pc and ras_count unchanged. Release stall -> the push happens once.
- reset asserted mid-sequence with stall=1 and ras_count=2 -> next edge gives pc = 0x00400000, ras_count = 0, overflow cleared. ADDR_W=16 build: pc = 0xFFFC plus sequential step -> 0x0000.
